hs_fifo_bridge: RTL and testbench

Elastic buffer that joins two four-phase req/ack stages, e.g. the output port of one `filter` instance to the input port of the next. Both sides act as the handshake responder: upstream raises `req_wr` with data, and the bridge captures it and acknowledges. Downstream raises `req_rd`, and the bridge drives data and acknowledges. A DEPTH-entry FIFO decouples the two sides so that chained stages need not run in lockstep.

---
 rtl/hs_pkg.sv | 8 +
 rtl/hs_fifo_mem.sv | 19 +
 rtl/hs_fifo_bridge.sv | 59 +++++
 tb/tb_hs_fifo_bridge.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// hs_pkg: shared defaults and FSM state encodings for the handshake FIFO bridge
package hs_pkg;
  localparam int HS_DWIDTH = 16;
  localparam logic W_IDLE = 1'b0;
  localparam logic W_ACK = 1'b1;
  localparam logic R_IDLE = 1'b0;
  localparam logic R_ACK = 1'b1;
endpackage

// File: rtl/hs_fifo_mem.sv
// hs_fifo_mem: DEPTH x DWIDTH register array, one sync write port, one comb read port
module hs_fifo_mem import hs_pkg::*; #(
  parameter int DWIDTH = HS_DWIDTH,
  parameter int DEPTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [0:DWIDTH-1] i_wdata,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [0:DWIDTH-1] o_rdata
);
  logic [0:DWIDTH-1] r_mem [DEPTH];
  // contents are not reset; only written slots are ever read
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/hs_fifo_bridge.sv
// hs_fifo_bridge: four-phase req/ack responder on both sides of a DEPTH-entry FIFO
module hs_fifo_bridge import hs_pkg::*; #(
  parameter int DWIDTH = HS_DWIDTH,
  parameter int DEPTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_wr,
  output logic              ack_wr,
  input  logic [0:DWIDTH-1] data_wr,
  input  logic              req_rd,
  output logic              ack_rd,
  output logic [0:DWIDTH-1] data_rd,
  output logic [AWIDTH:0]   count
);
  localparam logic [AWIDTH:0] PTR_ONE = (AWIDTH+1)'(1);
  logic r_ws, w_ws_nxt, r_rs, w_rs_nxt;
  logic [AWIDTH:0] r_wptr, r_rptr;
  logic [0:DWIDTH-1] w_mem_rd;
  logic w_full, w_empty, w_do_wr, w_do_rd;
  // status flags, transfer acceptance and next-state for both handshake FSMs
  always_comb begin
    w_empty = r_wptr == r_rptr;
    w_full = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) && (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);
    w_do_wr = (r_ws == W_IDLE) && req_wr && !w_full;
    w_do_rd = (r_rs == R_IDLE) && req_rd && !w_empty;
    w_ws_nxt = (r_ws == W_IDLE) ? (w_do_wr ? W_ACK : W_IDLE) : (req_wr ? W_ACK : W_IDLE);
    w_rs_nxt = (r_rs == R_IDLE) ? (w_do_rd ? R_ACK : R_IDLE) : (req_rd ? R_ACK : R_IDLE);
  end
  // FSM state, pointers and the registered read data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ws <= W_IDLE;
      r_rs <= R_IDLE;
      r_wptr <= '0;
      r_rptr <= '0;
      data_rd <= '0;
    end else begin
      r_ws <= w_ws_nxt;
      r_rs <= w_rs_nxt;
      if (w_do_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_rd) begin
        r_rptr <= r_rptr + PTR_ONE;
        data_rd <= w_mem_rd;
      end
    end
  assign ack_wr = r_ws == W_ACK;
  assign ack_rd = r_rs == R_ACK;
  assign count = r_wptr - r_rptr;
  hs_fifo_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_mem (
    .clk(clk),
    .i_we(w_do_wr),
    .i_waddr(r_wptr[AWIDTH-1:0]),
    .i_wdata(data_wr),
    .i_raddr(r_rptr[AWIDTH-1:0]),
    .o_rdata(w_mem_rd)
  );
endmodule

// File: tb/tb_hs_fifo_bridge.sv
// tb_hs_fifo_bridge: directed and randomized four-phase traffic against a queue model
module tb_hs_fifo_bridge;
  logic clk = 0, rst = 1, req_wr = 0, req_rd = 0, ack_wr, ack_rd;
  logic [0:15] data_wr = '0, data_rd;
  logic [3:0] count;
  logic [15:0] q[$];
  int checks = 0, errors = 0;
  bit wdone, rdone;
  hs_fifo_bridge dut (
    .clk(clk), .rst(rst), .req_wr(req_wr), .ack_wr(ack_wr), .data_wr(data_wr),
    .req_rd(req_rd), .ack_rd(ack_rd), .data_rd(data_rd), .count(count)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ack(input bit side_rd, input logic lvl);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((side_rd ? ack_rd : ack_wr) !== lvl) && n < 50);
    check(side_rd ? "rd_ack_wait" : "wr_ack_wait", side_rd ? ack_rd : ack_wr, lvl);
  endtask
  task automatic wr(input logic [15:0] d);
    data_wr = d;
    req_wr = 1;
    wait_ack(0, 1);
    q.push_back(d);
    req_wr = 0;
    wait_ack(0, 0);
    check("wr_count", count, q.size());
  endtask
  task automatic rd();
    logic [15:0] e;
    req_rd = 1;
    wait_ack(1, 1);
    e = q.pop_front();
    check("rd_data", data_rd, e);
    req_rd = 0;
    wait_ack(1, 0);
    check("rd_count", count, q.size());
  endtask
  initial begin
    @(negedge clk);
    check("rst_ack_wr", ack_wr, 0);
    check("rst_ack_rd", ack_rd, 0);
    check("rst_data_rd", data_rd, 0);
    check("rst_count", count, 0);
    rst = 0;
    @(negedge clk);
    data_wr = 16'h1234;
    req_wr = 1;
    @(negedge clk);
    check("single_ack_wr", ack_wr, 1);
    check("single_count1", count, 1);
    req_wr = 0;
    @(negedge clk);
    check("single_wr_rel", ack_wr, 0);
    req_rd = 1;
    @(negedge clk);
    check("single_ack_rd", ack_rd, 1);
    check("single_data", data_rd, 16'h1234);
    check("single_count0", count, 0);
    req_rd = 0;
    @(negedge clk);
    check("single_rd_rel", ack_rd, 0);
    for (int i = 1; i <= 8; i++) wr(16'(0 - i));
    check("full_count", count, 8);
    data_wr = 16'h0009;
    req_wr = 1;
    repeat (3) begin
      @(negedge clk);
      check("full_stall", ack_wr, 0);
    end
    req_rd = 1;
    @(negedge clk);
    check("full_rd_ack", ack_rd, 1);
    check("full_rd_data", data_rd, 16'hFFFF);
    check("full_wr_not_yet", ack_wr, 0);
    void'(q.pop_front());
    @(negedge clk);
    check("full_wr_next", ack_wr, 1);
    check("full_count_again", count, 8);
    q.push_back(16'h0009);
    req_wr = 0;
    req_rd = 0;
    @(negedge clk);
    repeat (8) rd();
    check("drained", count, 0);
    req_rd = 1;
    repeat (5) begin
      @(negedge clk);
      check("empty_wait", ack_rd, 0);
    end
    data_wr = 16'h7FFF;
    req_wr = 1;
    @(negedge clk);
    check("empty_wr_ack", ack_wr, 1);
    check("empty_no_bypass", ack_rd, 0);
    @(negedge clk);
    check("empty_rd_ack", ack_rd, 1);
    check("empty_rd_data", data_rd, 16'h7FFF);
    req_wr = 0;
    req_rd = 0;
    repeat (2) @(negedge clk);
    check("empty_count", count, 0);
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          data_wr = 16'(i);
          req_wr = 1;
          wait_ack(0, 1);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          req_wr = 0;
          wait_ack(0, 0);
        end
        wdone = 1;
      end
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          req_rd = 1;
          wait_ack(1, 1);
          check("wrap_data", data_rd, 16'(i));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          req_rd = 0;
          wait_ack(1, 0);
        end
        rdone = 1;
      end
      begin
        int n = 0;
        while (!(wdone && rdone) && n < 8000) begin
          @(negedge clk);
          n++;
          check("wrap_count_max", count <= 4'd8, 1);
        end
      end
    join
    check("wrap_count_end", count, 0);
    wr(16'hA001);
    wr(16'hA002);
    data_wr = 16'hA003;
    req_wr = 1;
    @(negedge clk);
    check("mid_ack_wr", ack_wr, 1);
    check("mid_count3", count, 3);
    rst = 1;
    q.delete();
    #1;
    check("mid_rst_ack_wr", ack_wr, 0);
    check("mid_rst_ack_rd", ack_rd, 0);
    check("mid_rst_data_rd", data_rd, 0);
    check("mid_rst_count", count, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post_rst_ack_wr", ack_wr, 1);
    check("post_rst_count", count, 1);
    q.push_back(16'hA003);
    req_wr = 0;
    wait_ack(0, 0);
    rd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
